// File: rtl/pwm_light_pkg.sv
// Shared definitions for the PWM light path: fade FSM states and level-code clamping.
package pwm_light_pkg;

  typedef enum logic [1:0] {
    StSettled,
    StPending,
    StFading
  } fade_state_e;

  // Codes beyond the number of real levels fall back to "off".
  function automatic int unsigned clamp_level(input int unsigned code,
                                              input int unsigned num_levels);
    return (code > num_levels) ? 0 : code;
  endfunction

endpackage

// File: rtl/pwm_sel_mux.sv
// Combinational N:1 PWM selector; level 0 is off, level k picks pwm_i[k-1].
module pwm_sel_mux #(
  parameter int unsigned NUM_LEVELS = 4,
  parameter int unsigned SEL_W      = $clog2(NUM_LEVELS + 1)
) (
  input  logic [NUM_LEVELS-1:0] pwm_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic                  pwm_o
);

  always_comb begin
    pwm_o = 1'b0;
    for (int unsigned k = 1; k <= NUM_LEVELS; k++) begin
      if (sel_i == SEL_W'(k)) begin
        pwm_o = pwm_i[k-1];
      end
    end
  end

endmodule

// File: rtl/pwm_level_mux.sv
// Glitch-free PWM brightness selector: switches level only at period boundaries,
// either jumping straight to the requested level or fading one level at a time.
module pwm_level_mux
  import pwm_light_pkg::*;
#(
  parameter int unsigned NUM_LEVELS = 4,
  parameter int unsigned SEL_W      = $clog2(NUM_LEVELS + 1),
  parameter int unsigned FADE_DIV   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_LEVELS-1:0] i_pwm,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_period_start,
  input  logic                  i_fade_en,
  output logic                  o_pwm,
  output logic [SEL_W-1:0]      o_level,
  output logic                  o_busy
);

  localparam int unsigned CntW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FADE_DIV - 1);

  logic [SEL_W-1:0] target_d, target_q;
  logic [SEL_W-1:0] applied_d, applied_q;
  logic [CntW-1:0]  fade_cnt_d, fade_cnt_q;
  logic             busy_q;
  logic             pwm_q;
  logic             mux_pwm;
  fade_state_e      state;

  // State is a pure function of the current registers and the fade enable.
  always_comb begin
    target_d   = SEL_W'(clamp_level(32'(i_sel), NUM_LEVELS));
    applied_d  = applied_q;
    fade_cnt_d = fade_cnt_q;

    if (applied_q == target_q) begin
      state = StSettled;
    end else if (i_fade_en) begin
      state = StFading;
    end else begin
      state = StPending;
    end

    unique case (state)
      StSettled: fade_cnt_d = '0;
      StPending: begin
        fade_cnt_d = '0;
        if (i_period_start) begin
          applied_d = target_q;
        end
      end
      StFading: begin
        if (i_period_start) begin
          if (fade_cnt_q == CntLast) begin
            fade_cnt_d = '0;
            // Direction is taken from the live target so a reversal never overshoots.
            applied_d  = (applied_q < target_q) ? applied_q + SEL_W'(1)
                                                : applied_q - SEL_W'(1);
          end else begin
            fade_cnt_d = fade_cnt_q + CntW'(1);
          end
        end
      end
      default: fade_cnt_d = '0;
    endcase
  end

  // Mux driven by the next applied level so o_pwm and o_level switch on the same edge.
  pwm_sel_mux #(
    .NUM_LEVELS (NUM_LEVELS),
    .SEL_W      (SEL_W)
  ) u_sel_mux (
    .pwm_i (i_pwm),
    .sel_i (applied_d),
    .pwm_o (mux_pwm)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      target_q   <= '0;
      applied_q  <= '0;
      fade_cnt_q <= '0;
      busy_q     <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      target_q   <= target_d;
      applied_q  <= applied_d;
      fade_cnt_q <= fade_cnt_d;
      busy_q     <= (applied_q != target_q);
      pwm_q      <= mux_pwm;
    end
  end

  assign o_pwm   = pwm_q;
  assign o_level = applied_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_pwm_level_mux.sv
// Scoreboard bench for pwm_level_mux: directed scenarios plus randomized traffic
// checked against a behavioural model of the level-selection rules.
module tb_pwm_level_mux;

  localparam int N  = 4;
  localparam int FD = 2;
  localparam int SW = 3;

  logic          i_clk;
  logic          i_reset;
  logic [N-1:0]  i_pwm;
  logic [SW-1:0] i_sel;
  logic          i_period_start;
  logic          i_fade_en;
  logic          o_pwm;
  logic [SW-1:0] o_level;
  logic          o_busy;

  pwm_level_mux #(
    .NUM_LEVELS (N),
    .FADE_DIV   (FD)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_pwm          (i_pwm),
    .i_sel          (i_sel),
    .i_period_start (i_period_start),
    .i_fade_en      (i_fade_en),
    .o_pwm          (o_pwm),
    .o_level        (o_level),
    .o_busy         (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    int pwm;
    int level;
    int busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: requested level, level in use, boundaries counted toward a fade step.
  int m_want    = 0;
  int m_applied = 0;
  int m_bounds  = 0;

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_want    = 0;
    m_applied = 0;
    m_bounds  = 0;
  endtask

  // Predict outputs right after the coming clock edge.
  task automatic model_step(input int sel, input int pwm, input bit ps, input bit fe);
    exp_t e;
    int   nxt;
    nxt    = m_applied;
    e.busy = (m_applied != m_want) ? 1 : 0;
    if (m_applied == m_want || !fe) begin
      m_bounds = 0;
      if (ps) nxt = m_want;
    end else if (ps) begin
      m_bounds = m_bounds + 1;
      if (m_bounds == FD) begin
        m_bounds = 0;
        nxt = (m_want > m_applied) ? m_applied + 1 : m_applied - 1;
      end
    end
    e.level   = nxt;
    e.pwm     = (nxt == 0) ? 0 : ((pwm >> (nxt - 1)) & 1);
    m_applied = nxt;
    m_want    = (sel > N) ? 0 : sel;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input int sel, input bit ps, input bit fe);
    int pwm;
    @(negedge i_clk);
    pwm            = int'($urandom_range(0, (1 << N) - 1));
    i_reset        = 1'b0;
    i_sel          = SW'(sel);
    i_pwm          = N'(pwm);
    i_period_start = ps;
    i_fade_en      = fe;
    model_step(sel, pwm, ps, fe);
  endtask

  // n boundaries, each preceded by gap idle cycles.
  task automatic bounds(input int n, input int gap, input int sel, input bit fe);
    for (int b = 0; b < n; b++) begin
      for (int g = 0; g < gap; g++) cycle(sel, 1'b0, fe);
      cycle(sel, 1'b1, fe);
    end
  endtask

  task automatic check_level(input string name, input int want);
    @(posedge i_clk);
    #2;
    chk(name, int'(o_level), want);
  endtask

  task automatic do_reset(input string name);
    @(negedge i_clk);
    i_reset        = 1'b1;
    i_sel          = '0;
    i_period_start = 1'b0;
    #1;
    chk({name, "_pwm"}, int'(o_pwm), 0);
    chk({name, "_level"}, int'(o_level), 0);
    chk({name, "_busy"}, int'(o_busy), 0);
    model_reset();
  endtask

  // Monitor: every edge with a pending prediction is compared against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("o_pwm", int'(o_pwm), e.pwm);
        chk("o_level", int'(o_level), e.level);
        chk("o_busy", int'(o_busy), e.busy);
      end
    end
  end

  initial begin
    int sel;
    bit fe;
    i_reset        = 1'b1;
    i_pwm          = '0;
    i_sel          = '0;
    i_period_start = 1'b0;
    i_fade_en      = 1'b0;
    #7;
    chk("reset_pwm", int'(o_pwm), 0);
    chk("reset_level", int'(o_level), 0);
    chk("reset_busy", int'(o_busy), 0);

    // Jump 0 -> 3 with the boundary ten cycles after the request.
    bounds(1, 10, 3, 1'b0);
    check_level("jump_level", 3);
    cycle(3, 1'b0, 1'b0);
    cycle(3, 1'b0, 1'b0);
    bounds(1, 2, 0, 1'b0);

    // Fade 0 -> 4, two boundaries per step.
    bounds(8, 2, 4, 1'b1);
    check_level("fade_level", 4);
    cycle(4, 1'b0, 1'b1);
    cycle(4, 1'b0, 1'b1);
    @(posedge i_clk);
    #2;
    chk("fade_busy_clear", int'(o_busy), 0);

    // Reverse mid-fade: up to 3, then back down to 1.
    bounds(1, 1, 0, 1'b0);
    bounds(6, 2, 4, 1'b1);
    check_level("rev_mid_level", 3);
    bounds(4, 2, 1, 1'b1);
    check_level("rev_end_level", 1);

    // Out-of-range request clamps to off.
    bounds(1, 2, 7, 1'b0);
    check_level("clamp_level", 0);
    #0 chk("clamp_pwm", int'(o_pwm), 0);

    // Request coinciding with a boundary waits for the next one.
    cycle(2, 1'b1, 1'b0);
    check_level("coincident_hold", 0);
    bounds(1, 3, 2, 1'b0);
    check_level("coincident_switch", 2);

    // Reset in the middle of a fade.
    bounds(1, 1, 0, 1'b0);
    bounds(4, 2, 4, 1'b1);
    check_level("pre_reset_level", 2);
    do_reset("midfade_reset");
    for (int i = 0; i < 3; i++) cycle(0, 1'b0, 1'b0);

    // Randomized traffic.
    sel = 0;
    fe  = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) sel = int'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) fe = ~fe;
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rand_reset");
      end
      cycle(sel, ($urandom_range(0, 3) == 0), fe);
    end

    repeat (3) @(posedge i_clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
